// File: rtl/serial_subtractor_4b_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_4b_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor_1b.sv
// One-bit full subtractor: x - y - bi, producing the difference bit and borrow-out.
module full_subtractor_1b (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor_4b.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per cycle,
// and publishes the difference and borrow-out together with a one-cycle done pulse.
module serial_subtractor_4b
    import serial_subtractor_4b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int IDX_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;

    logic               w_load;
    logic               w_shift;
    logic               w_last;
    logic [IDX_W-1:0]   w_idx;
    logic               w_diff;
    logic               w_bo;
    logic [WIDTH-1:0]   w_sh_next;

    assign w_idx     = r_cnt[IDX_W-1:0];
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_sh_next = {w_diff, r_sh[WIDTH-1:1]};

    full_subtractor_1b u_fs (
        .x    (r_a[w_idx]),
        .y    (r_b[w_idx]),
        .bi   (r_br),
        .diff (w_diff),
        .bo   (w_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Result registers load only on the final shift, so partial sums never reach d.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_sh   <= '0;
            r_d    <= '0;
            r_bout <= 1'b0;
        end else if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
            r_sh  <= '0;
        end else if (w_shift) begin
            r_sh  <= w_sh_next;
            r_br  <= w_bo;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_d    <= w_sh_next;
                r_bout <= w_bo;
            end
        end
    end

    assign d    = r_d;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_4b.sv
// Directed and exhaustive self-checking bench for serial_subtractor_4b at WIDTH=4.
module tb_serial_subtractor_4b;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] prev_d;
    logic         prev_bout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] ed;
        logic         eb;
    } vec_t;

    vec_t vecs[6];

    serial_subtractor_4b #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for IDLE, presents operands for one edge, then scrambles the inputs.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1;
        a     = av;
        b     = bv;
        bin   = binv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        bin   = ~binv;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!done) begin
                chk("busy_in_shift", int'(busy), 1);
                chk("d_hidden", int'(d), int'(prev_d));
            end
        end while (!done && lat < 20);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                          input logic [W-1:0] ed, input logic eb);
        int lat;
        start_op(av, bv, binv);
        wait_done(lat);
        chk("latency", lat, W);
        chk("d", int'(d), int'(ed));
        chk("bout", int'(bout), int'(eb));
        prev_d    = ed;
        prev_bout = eb;
        @(posedge clk);
        #1;
        chk("done_pulse_len", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        int n_done;
        int busy_rises;
        logic last_busy;
        logic [W:0] exp5;

        vecs[0] = '{a: 4'd9,  b: 4'd2,  bin: 1'b0, ed: 4'b0111, eb: 1'b0};
        vecs[1] = '{a: 4'd2,  b: 4'd5,  bin: 1'b0, ed: 4'b1101, eb: 1'b1};
        vecs[2] = '{a: 4'd10, b: 4'd5,  bin: 1'b1, ed: 4'b0100, eb: 1'b0};
        vecs[3] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, ed: 4'b1111, eb: 1'b1};
        vecs[4] = '{a: 4'd15, b: 4'd15, bin: 1'b0, ed: 4'b0000, eb: 1'b0};
        vecs[5] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, ed: 4'b0000, eb: 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        prev_d = '0; prev_bout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_bout", int'(bout), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].ed, vecs[i].eb);
        end

        // Outputs hold while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold_d", int'(d), int'(prev_d));
        chk("idle_hold_bout", int'(bout), int'(prev_bout));
        chk("idle_busy", int'(busy), 0);

        // Second start in the 2nd SHIFT cycle is ignored.
        start_op(4'd9, 4'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 4'd15; b = 4'd15; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_done = 0; busy_rises = 0; last_busy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                chk("ign_d", int'(d), 7);
                chk("ign_bout", int'(bout), 0);
            end
            if (busy && !last_busy) busy_rises++;
            last_busy = busy;
        end
        chk("ign_done_count", n_done, 1);
        chk("ign_busy_contig", busy_rises, 0);
        chk("ign_final_d", int'(d), 7);
        prev_d = 4'd7; prev_bout = 1'b0;

        // Reset in the 3rd SHIFT cycle aborts the operation.
        start_op(4'd9, 4'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_d", int'(d), 0);
        chk("abort_bout", int'(bout), 0);
        @(negedge clk);
        rst = 1'b0;
        prev_d = '0; prev_bout = 1'b0;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run_op(4'd15, 4'd0, 1'b0, 4'b1111, 1'b0);

        // Reset wins over start on the same edge.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 4'd3; b = 4'd1; bin = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_prio_busy", int'(busy), 0);
        chk("rst_prio_d", int'(d), 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        prev_d = '0; prev_bout = 1'b0;

        // Exhaustive back-to-back sweep.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp5 = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - 5'(ci);
                    run_op(4'(ai), 4'(bi), 1'(ci), exp5[W-1:0], exp5[W]);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_4b.md
SERIAL_SUBTRACTOR_4B -- requirements
Module: serial_subtractor_4b

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; SHALL be at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled with start.
REQ-006 b  input  WIDTH  subtrahend; sampled with start.
REQ-007 bin  input  1  borrow-in; sampled with start.
REQ-008 busy  output  1  high in SHIFT and DONE.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 d  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH.
REQ-011 bout  output  1  borrow-out; 1 iff a < b + bin, compared as unsigned values.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at a rising edge: the block SHALL latch a, b and bin into internal registers, clear the bit counter and enter SHIFT.
REQ-014 IDLE with start=0: the block SHALL stay in IDLE, and d and bout SHALL hold their values.
REQ-015 SHIFT SHALL process one bit per cycle, LSB first, using the bit index held by the counter.
REQ-016 Per bit: diff = a_i ^ b_i ^ br, and br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-017 The br register SHALL be loaded with bin on entry to SHIFT.
REQ-018 Each diff bit SHALL be shifted into a result register from the MSB side, so that after WIDTH shifts bit i sits at position i.
REQ-019 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE.
REQ-020 d and bout SHALL be updated on that same edge, with bout taken as the final br.
REQ-021 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE unconditionally.
REQ-022 Latency: start sampled at edge k gives done=1 in the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles from the start edge.
REQ-023 Back-to-back operation: start issued in the first IDLE cycle after DONE SHALL be accepted, giving one result per WIDTH+2 cycles.
REQ-024 start asserted in SHIFT or DONE SHALL be ignored, and operands presented then SHALL NOT affect the result in flight.
REQ-025 Changes on a, b or bin after the start edge SHALL NOT affect the result.
REQ-026 d and bout SHALL remain stable from the DONE edge until the next DONE edge or reset.
REQ-027 Intermediate shift-register contents SHALL NOT appear on d before DONE.
REQ-028 The bit counter SHALL be sized ceil(log2(WIDTH))+1 bits and SHALL NOT wrap during an operation.

Reset
REQ-029 rst=1 at a rising edge SHALL force: state=IDLE, busy=0, done=0, d=0, bout=0, internal registers=0.
REQ-030 rst SHALL take priority over start in the same cycle.
REQ-031 rst asserted during SHIFT or DONE SHALL abort the operation with no done pulse; the first start after reset release SHALL operate normally.

Structure
REQ-032 A shared package SHALL hold the state enumeration (IDLE, SHIFT, DONE) and the default-width constant.
REQ-033 One combinational sub-module, full_subtractor_1b (inputs x, y, bi; outputs diff, bo), SHALL implement REQ-016 and be instantiated once.
REQ-034 No other sub-modules SHALL be used; the FSM, counter and shift registers SHALL live in the top module.

Verification
REQ-035 The bench SHALL cover these directed scenarios with WIDTH=4:
- a=9, b=2, bin=0 -> d=0111, bout=0, done exactly 5 cycles after the start edge.
- a=2, b=5, bin=0 -> d=1101, bout=1.
- a=10, b=5, bin=1 -> d=0100, bout=0.
- a=0, b=0, bin=1 -> d=1111, bout=1.
- start pulsed again in the 2nd SHIFT cycle with a=15, b=15 -> ignored; first result intact; busy contiguous; one done only.
- rst in the 3rd SHIFT cycle -> no done, outputs 0 next cycle; subsequent a=15, b=0, bin=0 -> d=1111, bout=0.
REQ-036 The bench SHALL also run all 512 (a, b, bin) combinations back-to-back.
REQ-037 Each of those results SHALL be checked against {bout,d} = ({1'b0,a} - {1'b0,b} - bin) mod 32.
